d_cache: RTL and testbench
==========================

D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 7, meaning line-index bits (128 lines).
REQ-002 SHALL have parameter OFFSET_WIDTH, default 4, meaning byte-offset bits within a line (16 B = 4 words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_en  input  1  CPU memory-stage access enable.
REQ-006 SHALL have port data_wen  input  4  byte write strobes; 0 means a load.
REQ-007 SHALL have port data_addr  input  32  byte address.
REQ-008 SHALL have port data_wdata  input  32  store data, byte-lane aligned.
REQ-009 SHALL have port data_rdata  output  32  full load word.
REQ-010 SHALL have port d_stall  output  1  access not yet complete.
REQ-011 SHALL have port mem_rd_req / mem_rd_addr / mem_rd_addr_ok  out/out/in  1/32/1  line-refill request handshake.
REQ-012 SHALL have port mem_rd_valid / mem_rd_data  in/in  1/32  refill beats, one word per beat.
REQ-013 SHALL have port mem_wr_req / mem_wr_addr / mem_wr_addr_ok  out/out/in  1/32/1  line write-back request handshake.
REQ-014 SHALL have port mem_wr_data / mem_wr_ready  out/in  32/1  write-back beats; beat consumed when mem_wr_ready=1.

Function
REQ-015 SHALL be direct-mapped, write-back, write-allocate; address split: tag = addr[31:INDEX_WIDTH+OFFSET_WIDTH], index, word offset addr[OFFSET_WIDTH-1:2]; addr[1:0] ignored.
REQ-016 SHALL hold per line: valid, dirty, tag, and 2^(OFFSET_WIDTH-2) data words.
REQ-017 SHALL implement FSM states IDLE, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA.
REQ-018 SHALL define hit = data_en & valid[index] & (tag[index]==addr tag), evaluated combinationally in IDLE.
REQ-019 SHALL, on hit, drive d_stall=0 and data_rdata = addressed word in the same cycle (zero-wait hit).
REQ-020 SHALL, on store hit, write only the bytes selected by data_wen and set dirty at that clock edge.
REQ-021 SHALL drive d_stall = data_en & ~(state==IDLE & hit); data_en=0 gives d_stall=0, data_rdata don't-care.
REQ-022 SHALL, on miss in IDLE, go to WB_ADDR if victim valid & dirty, else RF_ADDR.
REQ-023 SHALL in WB_ADDR assert mem_wr_req with mem_wr_addr = {victim tag, index, OFFSET_WIDTH'b0}; on mem_wr_addr_ok go to WB_DATA, clear beat counter.
REQ-024 SHALL in WB_DATA present word[counter] on mem_wr_data; counter increments on mem_wr_ready; after the last word is accepted go to RF_ADDR.
REQ-025 SHALL in RF_ADDR assert mem_rd_req with mem_rd_addr = {addr tag, index, OFFSET_WIDTH'b0}; on mem_rd_addr_ok go to RF_DATA, clear counter.
REQ-026 SHALL in RF_DATA write mem_rd_data into word[counter] on each mem_rd_valid; on the last beat set valid=1, dirty=0, tag=addr tag, go to IDLE.
REQ-027 SHALL, after return to IDLE, re-evaluate the held request as a hit (one extra cycle); a store then merges bytes and sets dirty.
REQ-028 SHALL deassert mem_rd_req / mem_wr_req in the cycle following their addr_ok; never assert both simultaneously.
REQ-029 SHALL ignore mem_rd_valid, mem_wr_ready, addr_ok outside their states.
REQ-030 SHALL require CPU inputs held stable while d_stall=1; changes during a miss are undefined.
REQ-031 SHALL give miss latency = handshake cycles + beats + 1; with zero-wait memory clean miss = 1 (RF_ADDR) + 4 (beats) + 1 (hit) cycles.

Reset
REQ-032 SHALL, on rst=1 at any time, immediately clear all valid and dirty bits, counter=0, state=IDLE, mem_rd_req=0, mem_wr_req=0; data array contents undefined.
REQ-033 SHALL abort any burst in progress on reset without updating tag/valid; a partially refilled line stays invalid.

Verification
REQ-034 SHALL cover: after reset, load 0x0000_0040 -> d_stall=1, mem_rd_addr=0x0000_0040, 4 beats 0x11,0x22,0x33,0x44, then data_rdata=0x11, d_stall=0.
REQ-035 SHALL cover: load 0x0000_0048 right after -> hit, d_stall=0 same cycle, data_rdata=0x33, no mem request.
REQ-036 SHALL cover: store wen=4'b0011 wdata=0xAAAA_BBBB to 0x0000_0044, then load 0x0000_0044 -> data_rdata=0x0000_BBBB.
REQ-037 SHALL cover: load 0x0000_0840 (same index, new tag) -> write-back addr 0x0000_0040 beats 0x11,0x0000_BBBB,0x33,0x44 in order, then refill of 0x0000_0840.
REQ-038 SHALL cover: rst pulse mid RF_DATA after 2 beats -> mem_rd_req=0, d_stall=0 when data_en=0, next access to that line misses.
REQ-039 SHALL cover: mem_wr_ready held low 5 cycles in WB_DATA -> mem_wr_data stable, counter frozen, d_stall=1 throughout.

Source files
------------

// File: rtl/d_cache.sv
// Direct-mapped, write-back, write-allocate data cache with zero-wait hits.
// A miss evicts a dirty victim line, then refills the line one word per beat.
module d_cache #(
  parameter int unsigned INDEX_WIDTH  = 7,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_addr_ok,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  input  logic        mem_wr_addr_ok,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_ready
);

  localparam int unsigned TagW  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned CntW  = OFFSET_WIDTH - 2;
  localparam int unsigned Lines = 2 ** INDEX_WIDTH;
  localparam int unsigned Words = 2 ** CntW;
  localparam int unsigned AddrW = INDEX_WIDTH + CntW;

  typedef enum logic [2:0] {StIdle, StWbAddr, StWbData, StRfAddr, StRfData} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Lines-1:0]  valid_q, dirty_q;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [31:0]       data_q [Lines*Words];

  logic [TagW-1:0]        req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [CntW-1:0]        req_word;
  logic [AddrW-1:0]       word_ptr, beat_ptr;
  logic                   hit, idle_hit, store_hit, last_cnt, rf_beat, rf_last;
  logic                   unused_addr;

  assign req_tag     = data_addr[31 -: TagW];
  assign req_idx     = data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word    = data_addr[2 +: CntW];
  assign unused_addr = ^data_addr[1:0];
  assign word_ptr    = {req_idx, req_word};
  assign beat_ptr    = {req_idx, cnt_q};

  assign hit       = data_en & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign idle_hit  = (state_q == StIdle) & hit;
  assign store_hit = idle_hit & (|data_wen);
  assign last_cnt  = (cnt_q == CntW'(Words - 1));
  assign rf_beat   = (state_q == StRfData) & mem_rd_valid;
  assign rf_last   = rf_beat & last_cnt;

  assign d_stall     = data_en & ~idle_hit;
  assign data_rdata  = data_q[word_ptr];
  assign mem_rd_req  = (state_q == StRfAddr);
  assign mem_rd_addr = {req_tag, req_idx, {OFFSET_WIDTH{1'b0}}};
  assign mem_wr_req  = (state_q == StWbAddr);
  assign mem_wr_addr = {tag_q[req_idx], req_idx, {OFFSET_WIDTH{1'b0}}};
  assign mem_wr_data = data_q[beat_ptr];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (data_en && !hit) begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? StWbAddr : StRfAddr;
        end
      end
      StWbAddr: begin
        if (mem_wr_addr_ok) begin
          state_d = StWbData;
          cnt_d   = '0;
        end
      end
      StWbData: begin
        if (mem_wr_ready) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_cnt) state_d = StRfAddr;
        end
      end
      StRfAddr: begin
        if (mem_rd_addr_ok) begin
          state_d = StRfData;
          cnt_d   = '0;
        end
      end
      StRfData: begin
        if (mem_rd_valid) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_cnt) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset only invalidates; an interrupted refill therefore never becomes visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (rf_last) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (store_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_beat) begin
      data_q[beat_ptr] <= mem_rd_data;
    end else if (store_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_wen[b]) data_q[word_ptr][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
    if (rf_last) tag_q[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_d_cache.sv
// Bench for d_cache: directed scenarios then randomized accesses, checked against a
// flat-memory model plus a line directory that predicts hits, write-backs and refills.
module tb_d_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_addr_ok;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic        mem_wr_addr_ok;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_cache #(
    .INDEX_WIDTH (7),
    .OFFSET_WIDTH(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_en       (data_en),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .d_stall       (d_stall),
    .mem_rd_req    (mem_rd_req),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_addr_ok(mem_rd_addr_ok),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .mem_wr_req    (mem_wr_req),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_addr_ok(mem_wr_addr_ok),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ready  (mem_wr_ready)
  );

  // arch: latest value of every word as the CPU sees it; back: main memory contents.
  bit [31:0]   arch [int unsigned];
  bit [31:0]   back [int unsigned];
  bit          mv [128];
  bit          md [128];
  int unsigned mt [128];

  int          stalls;
  bit          first_stall, timed_out, proto_err, aborted, wb_seen, rf_seen;
  logic [31:0] wb_addr_obs, rf_addr_obs, rdata_obs;
  logic [31:0] wb_data_obs [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void ensure(input int unsigned a);
    if (!back.exists(a)) begin
      back[a] = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
      arch[a] = back[a];
    end
  endfunction

  function automatic void preload(input int unsigned a, input bit [31:0] v);
    back[a] = v;
    arch[a] = v;
  endfunction

  // Dirty data held only in the cache is lost when it is reset.
  function automatic void model_reset();
    for (int i = 0; i < 128; i++) begin
      if (mv[i] && md[i]) begin
        for (int k = 0; k < 4; k++) begin
          int unsigned a;
          a = (((mt[i] << 11) | (i << 4)) + 4 * k);
          ensure(a);
          arch[a] = back[a];
        end
      end
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endfunction

  // Entered and left on a falling edge; plays the memory side until the access completes.
  task automatic do_access(input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wdata, input bit jitter, input int hold,
                           input int abort_after);
    int          phase, beat, held;
    bit          prev_ok;
    logic [31:0] hold_word;
    phase = 0; beat = 0; held = 0; prev_ok = 1'b0; hold_word = '0;
    stalls = 0; timed_out = 0; proto_err = 0; aborted = 0; wb_seen = 0; rf_seen = 0;
    data_en = 1'b1; data_addr = addr; data_wen = wen; data_wdata = wdata;
    #1;
    first_stall = d_stall;
    while (d_stall) begin
      if (stalls >= 300) begin
        timed_out = 1'b1;
        break;
      end
      if (mem_rd_req && mem_wr_req) proto_err = 1'b1;
      if (prev_ok && (mem_rd_req || mem_wr_req)) proto_err = 1'b1;
      prev_ok = 1'b0;
      mem_rd_addr_ok = 1'b0; mem_wr_addr_ok = 1'b0; mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
      mem_rd_data = $urandom;
      if (phase == 0) begin
        if (mem_wr_req) begin
          if (!jitter || $urandom_range(0, 3) != 0) begin
            mem_wr_addr_ok = 1'b1; wb_seen = 1'b1; wb_addr_obs = mem_wr_addr;
            phase = 1; beat = 0; prev_ok = 1'b1;
          end
        end else if (mem_rd_req) begin
          if (!jitter || $urandom_range(0, 3) != 0) begin
            mem_rd_addr_ok = 1'b1; rf_seen = 1'b1; rf_addr_obs = mem_rd_addr;
            phase = 2; beat = 0; prev_ok = 1'b1;
          end
        end
      end else if (phase == 1) begin
        if (held < hold) begin
          if (held == 0) hold_word = mem_wr_data;
          else if (mem_wr_data !== hold_word) proto_err = 1'b1;
          held++;
        end else if (!jitter || $urandom_range(0, 3) != 0) begin
          mem_wr_ready = 1'b1;
          wb_data_obs[beat] = mem_wr_data;
          beat++;
          if (beat == 4) phase = 0;
        end
      end else begin
        if (abort_after > 0 && beat == abort_after) begin
          aborted = 1'b1;
          break;
        end
        if (!jitter || $urandom_range(0, 3) != 0) begin
          ensure(rf_addr_obs + 32'(4 * beat));
          mem_rd_valid = 1'b1;
          mem_rd_data  = back[rf_addr_obs + 32'(4 * beat)];
          beat++;
          if (beat == 4) phase = 0;
        end
      end
      @(posedge clk);
      @(negedge clk);
      stalls++;
    end
    mem_rd_addr_ok = 1'b0; mem_wr_addr_ok = 1'b0; mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
    if (aborted) return;
    rdata_obs = data_rdata;
    @(posedge clk);
    @(negedge clk);
    data_en = 1'b0; data_wen = 4'h0;
  endtask

  task automatic run_access(input logic [31:0] addr, input logic [3:0] wen,
                            input logic [31:0] wdata, input bit jitter, input int hold,
                            input int abort_after);
    int unsigned idx, tg, wa, la, va;
    bit          hit, wb;
    logic [31:0] exp_data, merged;
    logic [31:0] exp_wb [4];
    int          exp_stalls;
    idx = (addr >> 4) & 127;
    tg  = addr >> 11;
    wa  = addr & ~32'd3;
    la  = addr & ~32'd15;
    hit = mv[idx] && (mt[idx] == tg);
    wb  = !hit && mv[idx] && md[idx];
    va  = (mt[idx] << 11) | (idx << 4);
    for (int k = 0; k < 4; k++) begin
      ensure(la + 4 * k);
      exp_wb[k] = '0;
      if (wb) begin
        ensure(va + 4 * k);
        exp_wb[k] = arch[va + 4 * k];
      end
    end
    exp_data   = arch[wa];
    exp_stalls = hit ? 0 : (wb ? 11 + hold : 6);

    do_access(addr, wen, wdata, jitter, hold, abort_after);

    check("budget", 32'(timed_out), 32'd0);
    if (aborted) begin
      check("abort_rf_addr", rf_addr_obs, la);
      return;
    end
    check("proto", 32'(proto_err), 32'd0);
    check("hit", 32'(stalls == 0), 32'(hit));
    if (!jitter) check("stalls", 32'(stalls), 32'(exp_stalls));
    check("wb_seen", 32'(wb_seen), 32'(wb));
    if (wb && wb_seen) begin
      check("wb_addr", wb_addr_obs, va);
      for (int k = 0; k < 4; k++) check("wb_data", wb_data_obs[k], exp_wb[k]);
    end
    check("rf_seen", 32'(rf_seen), 32'(!hit));
    if (!hit && rf_seen) check("rf_addr", rf_addr_obs, la);
    if (wen == 4'h0) check("rdata", rdata_obs, exp_data);

    if (wb) for (int k = 0; k < 4; k++) back[va + 4 * k] = exp_wb[k];
    if (!hit) begin
      mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tg;
    end
    if (wen != 4'h0) begin
      merged = arch[wa];
      for (int b = 0; b < 4; b++) if (wen[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      arch[wa] = merged;
      md[idx]  = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    rst = 1'b1; data_en = 1'b0; data_wen = 4'h0; data_addr = '0; data_wdata = '0;
    mem_rd_addr_ok = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    mem_wr_addr_ok = 1'b0; mem_wr_ready = 1'b0;
    preload(32'h40, 32'h11); preload(32'h44, 32'h22);
    preload(32'h48, 32'h33); preload(32'h4C, 32'h44);
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(d_stall), 32'd0);
    check("rst_rd_req", 32'(mem_rd_req), 32'd0);
    check("rst_wr_req", 32'(mem_wr_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access(32'h40, 4'h0, 32'h0, 1'b0, 0, 0);
    check("miss_first_stall", 32'(first_stall), 32'd1);
    check("miss_rd_addr", rf_addr_obs, 32'h40);
    check("miss_data", rdata_obs, 32'h11);

    run_access(32'h48, 4'h0, 32'h0, 1'b0, 0, 0);
    check("hit_data", rdata_obs, 32'h33);
    check("hit_no_req", 32'(rf_seen), 32'd0);

    run_access(32'h44, 4'b0011, 32'hAAAA_BBBB, 1'b0, 0, 0);
    run_access(32'h44, 4'h0, 32'h0, 1'b0, 0, 0);
    check("store_merge", rdata_obs, 32'h0000_BBBB);

    run_access(32'h840, 4'h0, 32'h0, 1'b0, 5, 0);
    check("evict_wb_addr", wb_addr_obs, 32'h40);
    check("evict_wb_beat1", wb_data_obs[1], 32'h0000_BBBB);
    check("evict_rf_addr", rf_addr_obs, 32'h840);

    run_access(32'h1040, 4'h0, 32'h0, 1'b0, 0, 2);
    check("abort_taken", 32'(aborted), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rd_req", 32'(mem_rd_req), 32'd0);
    data_en = 1'b0;
    #1;
    check("abort_stall", 32'(d_stall), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_access(32'h1040, 4'h0, 32'h0, 1'b0, 0, 0);
    check("abort_line_misses", 32'(rf_seen), 32'd1);

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      run_access(a, w, $urandom, 1'b1,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
